// File: rtl/mem_tb_pkg.sv
// Shared types and defaults for the memory read-back checker.
// Holds the sweep FSM state encoding and the entry carried down
// the read-latency pipe.
package mem_tb_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } chk_state_t;

   // One outstanding read: where it went, what we expect back, and
   // whether that location was ever written (unwritten words are skipped).
   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] exp;
      logic                  vld;
   } pipe_entry_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// Delay line that carries each issued read's bookkeeping entry until
// the memory's read data for that read appears.  The last stage lines
// up with rdata; empty_next tells the FSM that once the current output
// entry retires nothing will be left in flight.
module rd_lat_pipe
   import mem_tb_pkg::*;
#(
   parameter int RD_LAT = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  pipe_entry_t push_entry,
   output logic        out_valid,
   output pipe_entry_t out_entry,
   output logic        empty_next
);

   pipe_entry_t       stage [RD_LAT];
   logic [RD_LAT-1:0] occ;
   logic [RD_LAT-1:0] upstream_occ;

   // Entry payload shifts every cycle; occupancy says which stages are real.
   always_ff @(posedge clk) begin
      stage[0] <= push_entry;
      for (int i = 1; i < RD_LAT; i++) begin
         stage[i] <= stage[i-1];
      end
   end

   // Occupancy bits follow the payload and are cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ <= '0;
      end else begin
         occ[0] <= push;
         for (int i = 1; i < RD_LAT; i++) begin
            occ[i] <= occ[i-1];
         end
      end
   end

   // Ignore the output stage: it retires this cycle, so only earlier stages count.
   always_comb begin
      upstream_occ             = occ;
      upstream_occ[RD_LAT-1]   = 1'b0;
      empty_next               = (upstream_occ == '0);
   end

   assign out_valid = occ[RD_LAT-1];
   assign out_entry = stage[RD_LAT-1];

endmodule

// File: rtl/mem_readback_checker.sv
// Read-back engine for the 16-word memory block.  Snoops the write port
// into a shadow copy, and on start sweeps every address through the read
// port, comparing returned words against the shadow value captured when
// each read was issued.
module mem_readback_checker
   import mem_tb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_LAT = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addrw,
   input  logic [DATA_W-1:0] wdata,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] addrr,
   input  logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] first_err_exp,
   output logic [DATA_W-1:0] first_err_got
);

   localparam int                DEPTH     = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] shadow [DEPTH];
   logic [DEPTH-1:0]  valid;
   chk_state_t        state;
   pipe_entry_t       issue_entry;
   pipe_entry_t       cmp_entry;
   logic              cmp_valid;
   logic              pipe_empty_next;
   logic              mismatch;

   // Shadow data mirrors every snooped write; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         shadow[addrw] <= wdata;
      end
   end

   // Valid bits mark words that have been written since reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[addrw] <= 1'b1;
      end
   end

   // Snapshot taken at issue time, before a same-cycle write lands (read-old-data).
   always_comb begin
      issue_entry.addr = addrr;
      issue_entry.exp  = shadow[addrr];
      issue_entry.vld  = valid[addrr];
   end

   rd_lat_pipe #(
      .RD_LAT(RD_LAT)
   ) u_pipe (
      .clk        (clk),
      .rst        (rst),
      .push       (rd_en),
      .push_entry (issue_entry),
      .out_valid  (cmp_valid),
      .out_entry  (cmp_entry),
      .empty_next (pipe_empty_next)
   );

   assign mismatch = cmp_valid && cmp_entry.vld && (rdata != cmp_entry.exp);

   // Sweep sequencing plus error accounting, all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         rd_en          <= 1'b0;
         addrr          <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         first_err_exp  <= '0;
         first_err_got  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= ISSUE;
                  rd_en          <= 1'b1;
                  addrr          <= '0;
                  busy           <= 1'b1;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  first_err_exp  <= '0;
                  first_err_got  <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE: begin
               if (addrr == LAST_ADDR) begin
                  state <= DRAIN;
                  rd_en <= 1'b0;
                  addrr <= '0;
               end else begin
                  addrr <= addrr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (pipe_empty_next) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
         if (mismatch) begin
            err_count <= err_count + (ADDR_W+1)'(1);
            if (err_count == '0) begin
               first_err_addr <= cmp_entry.addr;
               first_err_exp  <= cmp_entry.exp;
               first_err_got  <= rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_readback_checker.sv
// Bench for mem_readback_checker: a latency-1 instance checked every
// cycle against a cycle-arithmetic model, and a latency-3 instance
// checked with directed timing expectations.
module tb_mem_readback_checker;

   localparam int DEPTH = 16;
   localparam int LAT1  = 1;
   localparam int LAT3  = 3;

   logic        clk = 1'b0;
   logic        rst, wr_en, start1, start3;
   logic [3:0]  addrw;
   logic [15:0] wdata;

   logic        rd_en1, busy1, done1;
   logic [3:0]  addrr1, fa1;
   logic [15:0] rdata1, fe1, fg1;
   logic [4:0]  err1;

   logic        rd_en3, busy3, done3;
   logic [3:0]  addrr3, fa3;
   logic [15:0] rdata3, fe3, fg3;
   logic [4:0]  err3;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   logic        fault_en   = 1'b0;
   logic [3:0]  fault_addr = '0;
   logic [15:0] fault_data = '0;

   always #5 clk = ~clk;

   mem_readback_checker #(.ADDR_W(4), .DATA_W(16), .RD_LAT(LAT1)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .addrw(addrw), .wdata(wdata),
      .start(start1), .rd_en(rd_en1), .addrr(addrr1), .rdata(rdata1),
      .busy(busy1), .done(done1), .err_count(err1),
      .first_err_addr(fa1), .first_err_exp(fe1), .first_err_got(fg1)
   );

   mem_readback_checker #(.ADDR_W(4), .DATA_W(16), .RD_LAT(LAT3)) dut3 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .addrw(addrw), .wdata(wdata),
      .start(start3), .rd_en(rd_en3), .addrr(addrr3), .rdata(rdata3),
      .busy(busy3), .done(done3), .err_count(err3),
      .first_err_addr(fa3), .first_err_exp(fe3), .first_err_got(fg3)
   );

   // Memory block: shared write port, read-old-data on collision, per-instance latency.
   logic [15:0] mem [DEPTH];
   logic [15:0] rq1 [LAT1];
   logic [15:0] rq3 [LAT3];

   always @(posedge clk) begin
      if (rd_en1) rq1[0] <= (fault_en && addrr1 == fault_addr) ? fault_data : mem[addrr1];
      if (rd_en3) rq3[0] <= mem[addrr3];
      for (int i = 1; i < LAT3; i++) rq3[i] <= rq3[i-1];
      if (wr_en) mem[addrw] <= wdata;
   end

   assign rdata1 = rq1[LAT1-1];
   assign rdata3 = rq3[LAT3-1];

   // Reference model for the latency-1 instance, driven by sweep start time.
   typedef struct {
      int          vis;
      int          addr;
      logic [15:0] exp;
      logic [15:0] got;
   } miss_t;

   logic [15:0] m_shadow [DEPTH];
   bit          m_valid  [DEPTH];
   bit          m_active = 1'b0;
   int          m_T      = 0;
   int          m_err    = 0;
   logic [3:0]  m_fa     = '0;
   logic [15:0] m_fe     = '0;
   logic [15:0] m_fg     = '0;
   miss_t       pending [$];

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         m_active = 1'b0;
         m_err    = 0;
         m_fa     = '0;
         m_fe     = '0;
         m_fg     = '0;
         pending.delete();
         for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      end else begin
         if (m_active && cyc >= m_T + 2 && cyc <= m_T + DEPTH + 1) begin
            int          a;
            logic [15:0] got;
            miss_t       m;
            a   = cyc - m_T - 2;
            got = (fault_en && fault_addr == 4'(a)) ? fault_data : mem[a];
            if (m_valid[a] && got != m_shadow[a]) begin
               m.vis  = cyc + LAT1;
               m.addr = a;
               m.exp  = m_shadow[a];
               m.got  = got;
               pending.push_back(m);
            end
         end
         while (pending.size() > 0 && pending[0].vis == cyc) begin
            if (m_err == 0) begin
               m_fa = 4'(pending[0].addr);
               m_fe = pending[0].exp;
               m_fg = pending[0].got;
            end
            m_err = m_err + 1;
            void'(pending.pop_front());
         end
         if (start1 && !(m_active && (cyc - 1) >= m_T + 1 && (cyc - 1) <= m_T + DEPTH + LAT1)) begin
            m_T      = cyc - 1;
            m_active = 1'b1;
            m_err    = 0;
            m_fa     = '0;
            m_fe     = '0;
            m_fg     = '0;
            pending.delete();
         end
         if (wr_en) begin
            m_shadow[addrw] = wdata;
            m_valid[addrw]  = 1'b1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Every-cycle comparison of the latency-1 instance against the model.
   always @(negedge clk) begin
      if (cyc >= 1) begin
         int rel;
         bit e_rd, e_busy, e_done;
         rel    = cyc - m_T;
         e_rd   = m_active && rel >= 1 && rel <= DEPTH;
         e_busy = m_active && rel >= 1 && rel <= DEPTH + LAT1;
         e_done = m_active && rel == DEPTH + LAT1 + 1;
         checkOutput("rd_en", 32'(rd_en1), 32'(e_rd));
         checkOutput("busy", 32'(busy1), 32'(e_busy));
         checkOutput("done", 32'(done1), 32'(e_done));
         if (e_rd) checkOutput("addrr", 32'(addrr1), 32'(rel - 1));
         checkOutput("err_count", 32'(err1), 32'(m_err));
         checkOutput("first_err_addr", 32'(fa1), 32'(m_fa));
         checkOutput("first_err_exp", 32'(fe1), 32'(m_fe));
         checkOutput("first_err_got", 32'(fg1), 32'(m_fg));
      end
   end

   task automatic applyStimulus(input logic r, input logic we, input logic [3:0] a,
                                input logic [15:0] d, input logic s1, input logic s3);
      rst    = r;
      wr_en  = we;
      addrw  = a;
      wdata  = d;
      start1 = s1;
      start3 = s3;
      @(posedge clk);
      #1;
   endtask

   task automatic fillWords(input int lo, input int hi, input logic [15:0] base);
      for (int a = lo; a <= hi; a++) applyStimulus(1'b0, 1'b1, 4'(a), base + 16'(a), 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
   endtask

   // One sweep of the latency-1 instance, optionally colliding a write with one read.
   task automatic sweep1(input int coll_a, input logic [15:0] coll_d,
                         output int t0, output int done_at, output int rds);
      int n;
      n       = 0;
      done_at = -1;
      rds     = 0;
      t0      = cyc;
      applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
      while (done_at < 0 && n < 40) begin
         if (rd_en1) rds = rds + 1;
         if (done1) done_at = cyc;
         if (done_at < 0) begin
            if (coll_a >= 0 && cyc == t0 + 1 + coll_a)
               applyStimulus(1'b0, 1'b1, 4'(coll_a), coll_d, 1'b0, 1'b0);
            else
               applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
         end
         n = n + 1;
      end
   endtask

   initial begin
      int t0, done_at, rds, done_cnt;

      applyStimulus(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
      checkOutput("reset_rd_en", 32'(rd_en1), 32'd0);
      checkOutput("reset_addrr", 32'(addrr1), 32'd0);
      checkOutput("reset_busy", 32'(busy1), 32'd0);
      checkOutput("reset_err_count", 32'(err1), 32'd0);

      $display("[TB] clean full sweep");
      fillWords(0, 15, 16'h1000);
      sweep1(-1, 16'h0, t0, done_at, rds);
      checkOutput("clean_done_cycle", 32'(done_at), 32'(t0 + 18));
      checkOutput("clean_read_count", 32'(rds), 32'd16);
      checkOutput("clean_err_count", 32'(err1), 32'd0);

      $display("[TB] fault at address 5");
      fault_en   = 1'b1;
      fault_addr = 4'd5;
      fault_data = 16'hDEAD;
      sweep1(-1, 16'h0, t0, done_at, rds);
      checkOutput("fault_err_count", 32'(err1), 32'd1);
      checkOutput("fault_first_addr", 32'(fa1), 32'd5);
      checkOutput("fault_first_exp", 32'(fe1), 32'h1005);
      checkOutput("fault_first_got", 32'(fg1), 32'hDEAD);
      fault_en = 1'b0;

      $display("[TB] half fill, unwritten words skipped");
      applyStimulus(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
      fillWords(0, 7, 16'h1000);
      fault_en   = 1'b1;
      fault_addr = 4'd12;
      fault_data = 16'hDEAD;
      sweep1(-1, 16'h0, t0, done_at, rds);
      checkOutput("half_read_count", 32'(rds), 32'd16);
      checkOutput("half_done_cycle", 32'(done_at), 32'(t0 + 18));
      checkOutput("half_err_count", 32'(err1), 32'd0);
      fault_en = 1'b0;

      $display("[TB] same-cycle write collision at address 3");
      fillWords(8, 15, 16'h1000);
      sweep1(3, 16'hBEEF, t0, done_at, rds);
      checkOutput("coll_err_count", 32'(err1), 32'd0);
      sweep1(-1, 16'h0, t0, done_at, rds);
      checkOutput("coll2_err_count", 32'(err1), 32'd0);
      checkOutput("coll2_done_cycle", 32'(done_at), 32'(t0 + 18));

      $display("[TB] reset in the middle of a sweep");
      fault_en   = 1'b1;
      fault_addr = 4'd2;
      fault_data = 16'h0BAD;
      t0 = cyc;
      applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
      repeat (9) applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
      checkOutput("pre_rst_addrr", 32'(addrr1), 32'd9);
      checkOutput("pre_rst_err_count", 32'(err1), 32'd1);
      applyStimulus(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
      checkOutput("post_rst_busy", 32'(busy1), 32'd0);
      checkOutput("post_rst_rd_en", 32'(rd_en1), 32'd0);
      checkOutput("post_rst_err_count", 32'(err1), 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
         if (done1) done_cnt = done_cnt + 1;
      end
      checkOutput("post_rst_no_done", 32'(done_cnt), 32'd0);
      sweep1(-1, 16'h0, t0, done_at, rds);
      checkOutput("restart_read_count", 32'(rds), 32'd16);
      checkOutput("restart_done_cycle", 32'(done_at), 32'(t0 + 18));
      checkOutput("restart_err_count", 32'(err1), 32'd0);
      fault_en = 1'b0;

      $display("[TB] latency-3 instance with ignored restart");
      fillWords(0, 15, 16'h1000);
      t0       = cyc;
      done_at  = -1;
      done_cnt = 0;
      rds      = 0;
      applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++) begin
         if (rd_en3) rds = rds + 1;
         if (done3) begin
            done_cnt = done_cnt + 1;
            if (done_at < 0) done_at = cyc;
            checkOutput("lat3_err_at_done", 32'(err3), 32'd0);
            checkOutput("lat3_busy_at_done", 32'(busy3), 32'd0);
         end
         applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, (cyc == t0 + 5) ? 1'b1 : 1'b0);
      end
      checkOutput("lat3_done_cycle", 32'(done_at), 32'(t0 + 20));
      checkOutput("lat3_done_count", 32'(done_cnt), 32'd1);
      checkOutput("lat3_read_count", 32'(rds), 32'd16);
      checkOutput("lat3_busy_end", 32'(busy3), 32'd0);

      applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
